// File: rtl/cam_alloc_if.sv
// cam_alloc_if: request/result bundle for the self-allocating CAM.
// The master modport is the client side, the slave modport is the CAM.
interface cam_alloc_if #(
  parameter int unsigned DATA  = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WRITE = 2,
  parameter int unsigned READ  = 4,
  parameter int unsigned INV   = 2
);
  localparam int unsigned ADDR = $clog2(DEPTH);

  logic                             flush_;
  logic [WRITE-1:0]                 we_;
  logic [WRITE-1:0][DATA-1:0]       wd;
  logic [WRITE-1:0]                 wack;
  logic [WRITE-1:0][ADDR-1:0]       waddr;
  logic [INV-1:0]                   inv_;
  logic [INV-1:0][ADDR-1:0]         iaddr;
  logic [READ-1:0]                  re_;
  logic [READ-1:0][DATA-1:0]        rm;
  logic [READ-1:0][DATA-1:0]        rd;
  logic [READ-1:0]                  rvalid;
  logic [READ-1:0]                  match;
  logic [READ-1:0]                  multi;
  logic [READ-1:0][ADDR-1:0]        raddr;
  logic [ADDR:0]                    count;
  logic                             full;
  logic                             empty;

  modport master (
    output flush_, we_, wd, inv_, iaddr, re_, rm, rd,
    input  wack, waddr, rvalid, match, multi, raddr, count, full, empty
  );

  modport slave (
    input  flush_, we_, wd, inv_, iaddr, re_, rm, rd,
    output wack, waddr, rvalid, match, multi, raddr, count, full, empty
  );
endinterface

// File: rtl/cam_alloc.sv
// cam_alloc: self-allocating multi-port CAM with valid bits, invalidate,
// flush, occupancy tracking and a registered masked search.
// Optional feature: define CAM_ALLOC_BYPASS_EN to let a search see the
// allocations, invalidates and flush of its own cycle (post-edge view).
// TAIL = 1 (Enable): highest hit index wins; TAIL = 0 (Disable): lowest wins.
module cam_alloc #(
  parameter int unsigned DATA  = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WRITE = 2,
  parameter int unsigned READ  = 4,
  parameter int unsigned INV   = 2,
  parameter bit          TAIL  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  cam_alloc_if.slave   bus
);
  localparam int unsigned ADDR = $clog2(DEPTH);
  localparam int unsigned CW   = ADDR + 1;

  logic [DEPTH-1:0]           r_valid;
  logic [DATA-1:0]            r_data [DEPTH];
  logic [CW-1:0]              r_count;
  logic                       r_full;
  logic                       r_empty;
  logic [READ-1:0]            r_rvalid;
  logic [READ-1:0]            r_match;
  logic [READ-1:0]            r_multi;
  logic [READ-1:0][ADDR-1:0]  r_raddr;

  logic                       w_run;
  logic                       w_found;
  logic [DEPTH-1:0]           w_alloc;
  logic [DEPTH-1:0]           w_inv;
  logic [DEPTH-1:0]           w_valid_nxt;
  logic [DEPTH-1:0]           w_sval;
  logic [DATA-1:0]            w_wdata [DEPTH];
  logic [DATA-1:0]            w_sdata [DEPTH];
  logic [WRITE-1:0]           w_wack;
  logic [WRITE-1:0][ADDR-1:0] w_waddr;
  logic [CW-1:0]              w_cnt_nxt;
  logic [READ-1:0]            w_match;
  logic [READ-1:0]            w_multi;
  logic [READ-1:0][ADDR-1:0]  w_raddr;

  // Grants are suppressed during reset and on a flush cycle.
  assign w_run = reset & bus.flush_;

  // Allocation: active ports in ascending order take the lowest free entries.
  always_comb begin
    w_alloc = '0;
    w_wack  = '0;
    w_waddr = '0;
    w_found = 1'b0;
    for (int e = 0; e < DEPTH; e++) w_wdata[e] = '0;
    for (int k = 0; k < WRITE; k++) begin
      w_found = 1'b0;
      if (w_run && !bus.we_[k]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (!w_found && !r_valid[e] && !w_alloc[e]) begin
            w_found    = 1'b1;
            w_alloc[e] = 1'b1;
            w_wdata[e] = bus.wd[k];
            w_wack[k]  = 1'b1;
            w_waddr[k] = ADDR'(e);
          end
        end
      end
    end
  end

  // Next valid vector and occupancy; allocated entries were free, so an
  // invalidate aimed at one of them is a no-op and the allocation stands.
  always_comb begin
    w_inv = '0;
    for (int p = 0; p < INV; p++) begin
      if (!bus.inv_[p]) w_inv[bus.iaddr[p]] = 1'b1;
    end
    w_valid_nxt = bus.flush_ ? ((r_valid & ~w_inv) | w_alloc) : '0;
    w_cnt_nxt   = '0;
    for (int e = 0; e < DEPTH; e++) w_cnt_nxt = w_cnt_nxt + CW'(w_valid_nxt[e]);
  end

`ifdef CAM_ALLOC_BYPASS_EN
  // Search view: post-edge state, including same-cycle grants and clears.
  always_comb begin
    w_sval = w_valid_nxt;
    for (int e = 0; e < DEPTH; e++) w_sdata[e] = w_alloc[e] ? w_wdata[e] : r_data[e];
  end
`else
  // Search view: pre-edge state only.
  always_comb begin
    w_sval = r_valid;
    for (int e = 0; e < DEPTH; e++) w_sdata[e] = r_data[e];
  end
`endif

  // Masked compare per search port with hit count and priority select.
  always_comb begin
    w_match = '0;
    w_multi = '0;
    w_raddr = '0;
    for (int r = 0; r < READ; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (!bus.re_[r] && w_sval[e] &&
            (((bus.rd[r] ^ w_sdata[e]) & ~bus.rm[r]) == '0)) begin
          if (w_match[r]) w_multi[r] = 1'b1;
          if (TAIL || !w_match[r]) w_raddr[r] = ADDR'(e);
          w_match[r] = 1'b1;
        end
      end
    end
  end

  // Control state and registered search results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid  <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_rvalid <= '0;
      r_match  <= '0;
      r_multi  <= '0;
      r_raddr  <= '0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == CW'(DEPTH));
      r_empty  <= (w_cnt_nxt == '0);
      r_rvalid <= ~bus.re_;
      r_match  <= w_match;
      r_multi  <= w_multi;
      r_raddr  <= w_raddr;
    end
  end

  // Data array: written on grant, never reset.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (w_alloc[e]) r_data[e] <= w_wdata[e];
    end
  end

  assign bus.wack   = w_wack;
  assign bus.waddr  = w_waddr;
  assign bus.rvalid = r_rvalid;
  assign bus.match  = r_match;
  assign bus.multi  = r_multi;
  assign bus.raddr  = r_raddr;
  assign bus.count  = r_count;
  assign bus.full   = r_full;
  assign bus.empty  = r_empty;

endmodule

// File: tb/tb_cam_alloc.sv
// tb_cam_alloc: directed and random stimulus checked against a queue-based
// reference model of allocation, invalidation, flush and masked search.
module tb_cam_alloc;
  localparam int unsigned DATA  = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned WRITE = 2;
  localparam int unsigned READ  = 4;
  localparam int unsigned INV   = 2;
  localparam int unsigned ADDR  = $clog2(DEPTH);
  localparam bit          TAIL  = 1'b1;

  logic clk;
  logic rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DEPTH-1:0] m_valid;
  logic [DATA-1:0]  m_data [DEPTH];
  int               m_count;
  logic [READ-1:0]  e_rvalid;
  logic [READ-1:0]  e_match;
  logic [READ-1:0]  e_multi;
  int               e_raddr [READ];

  cam_alloc_if #(.DATA(DATA), .DEPTH(DEPTH), .WRITE(WRITE), .READ(READ), .INV(INV)) bus ();

  cam_alloc #(.DATA(DATA), .DEPTH(DEPTH), .WRITE(WRITE), .READ(READ), .INV(INV), .TAIL(TAIL)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.flush_ = 1'b1;
    bus.we_    = '1;
    bus.wd     = '0;
    bus.inv_   = '1;
    bus.iaddr  = '0;
    bus.re_    = '1;
    bus.rm     = '0;
    bus.rd     = '0;
  endtask

  // One clock: check grants against the model's free list, advance the
  // model, then check registered results after the edge.
  task automatic step();
    int               free_q[$];
    int               hits[$];
    logic [WRITE-1:0] xw;
    int               xa [WRITE];
    logic [DEPTH-1:0] nv;
    logic [DATA-1:0]  nd [DEPTH];
    logic [DEPTH-1:0] sv;
    logic [DATA-1:0]  sd [DEPTH];
    int               granted;
    int               dropped;
    int               cnt_nxt;
    bit               hit;
    #1;
    free_q = {};
    for (int e = 0; e < DEPTH; e++) if (!m_valid[e]) free_q.push_back(e);
    xw = '0;
    granted = 0;
    for (int k = 0; k < WRITE; k++) begin
      xa[k] = 0;
      if (bus.flush_ && !bus.we_[k] && free_q.size() > 0) begin
        xw[k] = 1'b1;
        xa[k] = free_q.pop_front();
        granted++;
      end
      check($sformatf("wack[%0d]", k), 32'(bus.wack[k]), 32'(xw[k]));
      check($sformatf("waddr[%0d]", k), 32'(bus.waddr[k]), 32'(xa[k]));
    end
    nv = m_valid;
    nd = m_data;
    dropped = 0;
    for (int e = 0; e < DEPTH; e++) begin
      hit = 1'b0;
      for (int p = 0; p < INV; p++) if (!bus.inv_[p] && int'(bus.iaddr[p]) == e) hit = 1'b1;
      if (m_valid[e] && hit) begin
        nv[e] = 1'b0;
        dropped++;
      end
    end
    for (int k = 0; k < WRITE; k++) begin
      if (xw[k]) begin
        nv[xa[k]] = 1'b1;
        nd[xa[k]] = bus.wd[k];
      end
    end
    if (!bus.flush_) begin
      nv = '0;
      cnt_nxt = 0;
    end else begin
      cnt_nxt = m_count + granted - dropped;
    end
`ifdef CAM_ALLOC_BYPASS_EN
    sv = nv;
    sd = nd;
`else
    sv = m_valid;
    sd = m_data;
`endif
    for (int r = 0; r < READ; r++) begin
      hits = {};
      e_rvalid[r] = !bus.re_[r];
      if (!bus.re_[r]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (sv[e] && (((bus.rd[r] ^ sd[e]) & ~bus.rm[r]) == '0)) hits.push_back(e);
        end
      end
      e_match[r] = (hits.size() > 0);
      e_multi[r] = (hits.size() > 1);
      e_raddr[r] = (hits.size() == 0) ? 0 : (TAIL ? hits[$] : hits[0]);
    end
    @(posedge clk);
    #1;
    m_valid = nv;
    m_data  = nd;
    m_count = cnt_nxt;
    for (int r = 0; r < READ; r++) begin
      check($sformatf("rvalid[%0d]", r), 32'(bus.rvalid[r]), 32'(e_rvalid[r]));
      check($sformatf("match[%0d]", r), 32'(bus.match[r]), 32'(e_match[r]));
      check($sformatf("multi[%0d]", r), 32'(bus.multi[r]), 32'(e_multi[r]));
      check($sformatf("raddr[%0d]", r), 32'(bus.raddr[r]), 32'(e_raddr[r]));
    end
    check("count", 32'(bus.count), 32'(m_count));
    check("full", 32'(bus.full), 32'(m_count == DEPTH));
    check("empty", 32'(bus.empty), 32'(m_count == 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'(0));
    check({tag, "_match"}, 32'(bus.match), 32'(0));
    check({tag, "_multi"}, 32'(bus.multi), 32'(0));
    check({tag, "_raddr"}, 32'(bus.raddr), 32'(0));
    check({tag, "_count"}, 32'(bus.count), 32'(0));
    check({tag, "_full"}, 32'(bus.full), 32'(0));
    check({tag, "_empty"}, 32'(bus.empty), 32'(1));
    check({tag, "_wack"}, 32'(bus.wack), 32'(0));
  endtask

  initial begin
    int f[$];
    rst_n   = 1'b0;
    m_valid = '0;
    m_count = 0;
    idle();
    bus.we_ = '0;
    #12;
    check_reset_outputs("rst");

    // Allocate two entries right after reset.
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    bus.we_   = '0;
    bus.wd[0] = 32'h100;
    bus.wd[1] = 32'h200;
    step();
    idle();
    step();

    // Masked search hits entry 0 only; unmasked miss.
    bus.re_[0] = 1'b0;
    bus.rd[0]  = 32'h1FF;
    bus.rm[0]  = 32'hFF;
    bus.re_[1] = 1'b0;
    bus.rd[1]  = 32'h800;
    step();
    idle();
    step();

    // Fill to full, placing synonyms 'h400 at entries 2 and 16.
    for (int it = 0; it < 40 && m_count < DEPTH; it++) begin
      idle();
      f = {};
      for (int e = 0; e < DEPTH; e++) if (!m_valid[e]) f.push_back(e);
      for (int k = 0; k < WRITE; k++) begin
        if (k < f.size()) begin
          bus.we_[k] = 1'b0;
          bus.wd[k]  = (f[k] == 2 || f[k] == 16) ? 32'h400 : 32'(32'h1000 + f[k]);
        end
      end
      step();
    end
    idle();
    for (int r = 0; r < READ; r++) begin
      bus.re_[r] = 1'b0;
      bus.rd[r]  = 32'h400;
    end
    bus.we_ = '0;
    step();

    // Free entry 5, then contend for it with both ports.
    idle();
    bus.inv_[0]  = 1'b0;
    bus.iaddr[0] = 5'd5;
    bus.inv_[1]  = 1'b0;
    bus.iaddr[1] = 5'd5;
    bus.we_      = '0;
    step();
    idle();
    bus.we_   = '0;
    bus.wd[0] = 32'h555;
    bus.wd[1] = 32'h666;
    step();

    // Same-cycle allocate and search of 'hABC.
    idle();
    bus.inv_[0]  = 1'b0;
    bus.iaddr[0] = 5'd7;
    step();
    idle();
    bus.we_[0] = 1'b0;
    bus.wd[0]  = 32'hABC;
    bus.re_[2] = 1'b0;
    bus.rd[2]  = 32'hABC;
    step();
    idle();
    bus.re_[2] = 1'b0;
    bus.rd[2]  = 32'hABC;
    step();

    // Flush with concurrent allocation requests and a search.
    idle();
    bus.flush_ = 1'b0;
    bus.we_    = '0;
    bus.re_[3] = 1'b0;
    bus.rd[3]  = 32'h400;
    step();

    // Randomised traffic.
    for (int it = 0; it < 400; it++) begin
      idle();
      bus.flush_ = ($urandom_range(0, 39) != 0);
      for (int k = 0; k < WRITE; k++) begin
        bus.we_[k] = 1'($urandom_range(0, 1));
        bus.wd[k]  = 32'($urandom_range(0, 7)) * 32'h111;
      end
      for (int p = 0; p < INV; p++) begin
        bus.inv_[p]  = 1'($urandom_range(0, 1));
        bus.iaddr[p] = ADDR'($urandom_range(0, DEPTH - 1));
      end
      for (int r = 0; r < READ; r++) begin
        bus.re_[r] = ($urandom_range(0, 3) == 0);
        bus.rd[r]  = 32'($urandom_range(0, 7)) * 32'h111;
        bus.rm[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
      end
      step();
    end

    // Reset asserted while search results are held.
    idle();
    bus.we_[0] = 1'b0;
    bus.wd[0]  = 32'h77;
    step();
    idle();
    for (int r = 0; r < READ; r++) begin
      bus.re_[r] = 1'b0;
      bus.rm[r]  = '1;
    end
    step();
    bus.we_ = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_valid = '0;
    m_count = 0;

    // First edge after release behaves as a normal cycle from empty.
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    bus.we_[1] = 1'b0;
    bus.wd[1]  = 32'h99;
    bus.re_[0] = 1'b0;
    bus.rm[0]  = '1;
    step();
    idle();
    bus.re_[0] = 1'b0;
    bus.rd[0]  = 32'h99;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
